// File: rtl/div_sequencer_if.sv
// Handshake and divider-side bundle for div_sequencer: operand request, divider
// control/result, and result delivery.
interface div_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_dividend;
    logic [31:0] in_divisor;
    logic        div_start;
    logic        div_stop;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient;
    logic [31:0] div_rest;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_quotient;
    logic [31:0] out_rest;
    logic        out_divzero;
    logic        busy;

    // The sequencer is the slave side; requester, divider and consumer form the master side.
    modport slave (
        input  in_valid, in_dividend, in_divisor, div_quotient, div_rest, out_ready,
        output in_ready, div_start, div_stop, div_dividend, div_divisor,
               out_valid, out_quotient, out_rest, out_divzero, busy
    );

    modport master (
        output in_valid, in_dividend, in_divisor, div_quotient, div_rest, out_ready,
        input  in_ready, div_start, div_stop, div_dividend, div_divisor,
               out_valid, out_quotient, out_rest, out_divzero, busy
    );
endinterface

// File: rtl/div_sequencer.sv
// Fixed-latency control sequencer for an external iterative divider.
// Optional feature macro DIVSEQ_DIVZERO_EN: zero divisors short-circuit straight to DONE.
module div_sequencer #(
    parameter int RUN_CYCLES = 32
) (
    input logic           clk,
    input logic           rst,
    div_sequencer_if.slave bus
);
    localparam int CW = $clog2(RUN_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(RUN_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, START, RUN, STOP, LOAD, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [31:0]   dividend_q, divisor_q, quotient_q, rest_q;
    logic          ready_q, start_q, stop_q, valid_q, busy_q;
`ifdef DIVSEQ_DIVZERO_EN
    logic          divzero_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: nxt is a block-local temporary, so it is assigned with '=' and read
        // in the same pass; every real flop below still uses '<='.
        state_t nxt;
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            quotient_q <= '0;
            rest_q     <= '0;
            ready_q    <= 1'b1;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
`ifdef DIVSEQ_DIVZERO_EN
            divzero_q  <= 1'b0;
`endif
        end else begin
            nxt = state;
            case (state)
                IDLE: if (bus.in_valid) begin
                    dividend_q <= bus.in_dividend;
                    divisor_q  <= bus.in_divisor;
                    nxt        = START;
`ifdef DIVSEQ_DIVZERO_EN
                    if (bus.in_divisor == '0) begin
                        quotient_q <= '1;
                        rest_q     <= bus.in_dividend;
                        divzero_q  <= 1'b1;
                        nxt        = DONE;
                    end
`endif
                end
                START: begin
                    cnt <= '0;
                    nxt = RUN;
                end
                RUN: begin
                    if (cnt == LAST) nxt = STOP;
                    else             cnt <= cnt + CW'(1);
                end
                STOP: nxt = LOAD;
                LOAD: begin
                    quotient_q <= bus.div_quotient;
                    rest_q     <= bus.div_rest;
`ifdef DIVSEQ_DIVZERO_EN
                    divzero_q  <= 1'b0;
`endif
                    nxt = DONE;
                end
                DONE:    if (bus.out_ready) nxt = IDLE;
                default: nxt = IDLE;
            endcase
            // Outputs are registered from the next state so they line up with it exactly.
            state   <= nxt;
            ready_q <= (nxt == IDLE);
            start_q <= (nxt == START);
            stop_q  <= (nxt == STOP);
            valid_q <= (nxt == DONE);
            busy_q  <= (nxt != IDLE);
        end
    end

    assign bus.in_ready     = ready_q;
    assign bus.div_start    = start_q;
    assign bus.div_stop     = stop_q;
    assign bus.div_dividend = dividend_q;
    assign bus.div_divisor  = divisor_q;
    assign bus.out_valid    = valid_q;
    assign bus.out_quotient = quotient_q;
    assign bus.out_rest     = rest_q;
    assign bus.busy         = busy_q;
`ifdef DIVSEQ_DIVZERO_EN
    assign bus.out_divzero  = divzero_q;
`else
    assign bus.out_divzero  = 1'b0;
`endif
endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter RUN_CYCLES, default 32: number of divider iteration clock cycles between start and stop.
REQ-002 clock  input  1  master clock; all state changes on the rising edge.
REQ-003 reset  input  1  master reset, asynchronous, active-high.
REQ-004 in_valid  input  1  requester presents an operand pair.
REQ-005 in_ready  output  1  sequencer can accept an operand pair.
REQ-006 in_dividend, in_divisor  input  32 each  unsigned operands.
REQ-007 div_start, div_stop  output  1 each  one-cycle pulses to the downstream divider.
REQ-008 div_dividend, div_divisor  output  32 each  operands driven to the divider.
REQ-009 div_quotient, div_rest  input  32 each  divider result registers.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_quotient, out_rest  output  32 each  held result.
REQ-013 out_divzero  output  1  result came from a zero divisor (see Configuration).
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, START, RUN, STOP, LOAD and DONE; all outputs SHALL be registered or decoded from the state only.
REQ-016 in_ready SHALL be 1 only in IDLE; accept means in_valid=1 and in_ready=1 at a rising edge.
REQ-017 On accept, the sequencer SHALL latch both operands and go to START; div_dividend and div_divisor SHALL hold the latched values, unchanged, until the next accept.
REQ-018 In START, div_start SHALL be 1 for exactly one cycle; next state RUN with the cycle counter cleared.
REQ-019 RUN SHALL last exactly RUN_CYCLES cycles, counted by a counter of width clog2(RUN_CYCLES)+1, and then go to STOP.
REQ-020 In STOP, div_stop SHALL be 1 for exactly one cycle; next state LOAD.
REQ-021 In LOAD, the sequencer SHALL sample div_quotient and div_rest into out_quotient and out_rest at the closing edge, then go to DONE.
REQ-022 Latency SHALL be fixed: out_valid rises RUN_CYCLES+3 edges after the accept edge (35 for the default).
REQ-023 In DONE, out_valid=1 and the outputs SHALL be held stable until out_ready=1 at an edge; that edge returns the FSM to IDLE.
REQ-024 out_valid=1 with out_ready=1 in the same cycle SHALL transfer immediately; in_ready rises in the following cycle, with no accept-to-DONE overlap.
REQ-025 div_start and div_stop SHALL never both be 1 and SHALL be 0 in all other states.
REQ-026 in_valid during a busy state SHALL be ignored, with no latching.

Reset
REQ-027 Reset SHALL force IDLE immediately, independent of clock, from any state including mid-RUN.
REQ-028 Reset values: in_ready=1 once reset is released; all other 1-bit outputs 0; all 32-bit outputs and internal registers 0; counter 0.
REQ-029 A division aborted by reset SHALL produce no out_valid; the first accept after reset SHALL behave as from power-up.

Configuration
REQ-030 Macro DIVSEQ_DIVZERO_EN: when defined, an accept with in_divisor=0 SHALL skip START/RUN/STOP/LOAD and go directly to DONE on the next edge, with out_quotient=32'hFFFFFFFF, out_rest=dividend and out_divzero=1; no div_start or div_stop pulse is issued.
REQ-031 When DIVSEQ_DIVZERO_EN is undefined, zero divisors SHALL follow the normal sequence and out_divzero SHALL be tied 0.

Verification
REQ-032 Accept 123456/789 with out_ready=1 -> div_start once, div_stop 33 cycles later, out_valid 35 edges after accept, quotient=156, rest=372.
REQ-033 Accept 100/7 with out_ready=0 for 10 cycles after out_valid -> quotient=14 and rest=2 held stable, in_ready=0 throughout; the out_ready pulse returns the FSM to IDLE.
REQ-034 Two back-to-back operand pairs (1000/10, 7/9) with in_valid held -> the second is accepted only after the first transfers; results are 100/0 and 0/7.
REQ-035 Assert reset asynchronously (mid-cycle) 12 cycles into RUN -> busy=0 and all outputs at reset values without a clock edge; no out_valid follows, and a subsequent 50/5 gives 10/0.
REQ-036 Accept 55/0 -> with DIVSEQ_DIVZERO_EN: out_valid one edge later, quotient=FFFFFFFF, rest=55, out_divzero=1, no div_start; without the macro: the full 35-edge sequence runs and out_divzero=0.
